// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK-flop modulo counter: JK excitation encodings
// ({j,k} pairs) and a helper that derives the excitation for one bit from its
// present and next value.
package jk_pkg;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // Returns {j,k} that moves one flop from q_bit to n_bit without ever
   // using the toggle encoding.
   function automatic logic [1:0] jk_excite(input logic q_bit, input logic n_bit);
      logic [1:0] jk;
      jk = {(~q_bit & n_bit), (q_bit & ~n_bit)};
      return jk;
   endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/status bundle of the JK modulo counter. The master drives the
// count controls, the slave (the counter) returns state and terminal count.
interface jk_mod_counter_if #(
   parameter int W = 4
);
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic [W-1:0] qb;
   logic         tc;

   modport master (output en, output up, output load, output d,
                   input q, input qb, input tc);
   modport slave  (input en, input up, input load, input d,
                   output q, output qb, output tc);
endinterface

// File: rtl/jk_mod_counter_jk_ff_cell.sv
// Single rising-edge JK flip-flop with asynchronous active-high reset to 0.
// Implements the full JK truth table including toggle; qb is held in its own
// flop so it is a true flop output and equals ~q at all times, reset included.
module jk_ff_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qb
);

   logic q_q;
   logic q_d;
   logic qb_q;

   // JK truth table: decide the next flop value from {j,k}.
   always_comb begin
      q_d = q_q;
      case ({j, k})
         JK_HOLD:   q_d = q_q;
         JK_RESET:  q_d = 1'b0;
         JK_SET:    q_d = 1'b1;
         JK_TOGGLE: q_d = ~q_q;
         default:   q_d = q_q;
      endcase
   end

   // Storage for q and its complement, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q  <= 1'b0;
         qb_q <= 1'b1;
      end else begin
         q_q  <= q_d;
         qb_q <= ~q_d;
      end
   end

   assign q  = q_q;
   assign qb = qb_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Synchronous modulo-MODULUS up/down counter built from W JK flip-flops.
// Next state is computed behaviourally, then converted into per-bit j/k
// excitation (toggle never used). Load clamps values >= MODULUS to MODULUS-1.
// Build option: define JK_COUNT_SAT_EN to saturate at the ends of the range
// instead of wrapping; the default build wraps.
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int W       = 4,
   parameter int MODULUS = 10
)(
   input  logic              clk,
   input  logic              rst,
   jk_mod_counter_if.slave   bus
);

   localparam logic [W:0]   MOD_EXT  = (W+1)'(MODULUS);
   localparam logic [W-1:0] MAX_VAL  = W'(MODULUS - 1);
   localparam logic [W-1:0] ZERO_VAL = {W{1'b0}};
   localparam logic [W-1:0] ONE_VAL  = W'(1);

   logic [W-1:0] q_s;
   logic [W-1:0] qb_s;
   logic [W-1:0] n_s;
   logic [W-1:0] j_s;
   logic [W-1:0] k_s;
   logic         at_max_s;
   logic         at_zero_s;

   // Range ends are found by compare, never by relying on W-bit overflow.
   assign at_max_s  = (q_s == MAX_VAL);
   assign at_zero_s = (q_s == ZERO_VAL);

   // Next-state selection: load (clamped) beats count, count beats hold.
   always_comb begin
      n_s = q_s;
      if (bus.load) begin
         if ({1'b0, bus.d} >= MOD_EXT) begin
            n_s = MAX_VAL;
         end else begin
            n_s = bus.d;
         end
      end else if (bus.en) begin
         if (bus.up) begin
`ifdef JK_COUNT_SAT_EN
            if (at_max_s) begin
               n_s = q_s;
            end else begin
               n_s = q_s + ONE_VAL;
            end
`else
            if (at_max_s) begin
               n_s = ZERO_VAL;
            end else begin
               n_s = q_s + ONE_VAL;
            end
`endif
         end else begin
`ifdef JK_COUNT_SAT_EN
            if (at_zero_s) begin
               n_s = q_s;
            end else begin
               n_s = q_s - ONE_VAL;
            end
`else
            if (at_zero_s) begin
               n_s = MAX_VAL;
            end else begin
               n_s = q_s - ONE_VAL;
            end
`endif
         end
      end else begin
         n_s = q_s;
      end
   end

   // Per-bit excitation: set bits that rise, reset bits that fall, else hold.
   always_comb begin
      j_s = {W{1'b0}};
      k_s = {W{1'b0}};
      for (int i = 0; i < W; i++) begin
         {j_s[i], k_s[i]} = jk_excite(q_s[i], n_s[i]);
      end
   end

   // One JK flip-flop per state bit.
   for (genvar g = 0; g < W; g++) begin : g_bit
      jk_ff_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (j_s[g]),
         .k   (k_s[g]),
         .q   (q_s[g]),
         .qb  (qb_s[g])
      );
   end

   assign bus.q  = q_s;
   assign bus.qb = qb_s;
   // Terminal count is combinational on the current state and controls.
   assign bus.tc = bus.en & ~bus.load & ((bus.up & at_max_s) | (~bus.up & at_zero_s));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter (W=4, MODULUS=10). The driver applies
// stimulus on the falling edge and pushes expected tc and next q into queues;
// an independent monitor pops and compares. The reference model is plain
// integer arithmetic on the counter value.
module tb_jk_mod_counter;

   localparam int W   = 4;
   localparam int MOD = 10;

   logic clk;
   logic rst;

   jk_mod_counter_if #(.W(W)) bus ();

   jk_mod_counter #(.W(W), .MODULUS(MOD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int m     = 0;
   int tc_exp_q[$];
   int q_exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int model_tc(input int c, input logic e, input logic u, input logic l);
      if (!e || l) return 0;
      if (u) return (c == MOD - 1) ? 1 : 0;
      return (c == 0) ? 1 : 0;
   endfunction

   function automatic int model_next(input int c, input logic e, input logic u,
                                     input logic l, input int dv);
      if (l) return (dv >= MOD) ? MOD - 1 : dv;
      if (!e) return c;
`ifdef JK_COUNT_SAT_EN
      if (u) return (c + 1 > MOD - 1) ? MOD - 1 : c + 1;
      return (c == 0) ? 0 : c - 1;
`else
      if (u) return (c + 1) % MOD;
      return (c + MOD - 1) % MOD;
`endif
   endfunction

   // Apply one cycle of stimulus at the falling edge and record expectations.
   task automatic step(input logic e, input logic u, input logic l, input int dv);
      bus.en   = e;
      bus.up   = u;
      bus.load = l;
      bus.d    = dv[W-1:0];
      tc_exp_q.push_back(model_tc(m, e, u, l));
      m = model_next(m, e, u, l, dv);
      q_exp_q.push_back(m);
      @(negedge clk);
   endtask

   // Monitor: tc after inputs settle, q and qb just after the rising edge.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         #2;
         if (tc_exp_q.size() > 0) begin
            e = tc_exp_q.pop_front();
            chk("tc", int'(bus.tc), e);
         end
         @(posedge clk);
         #1;
         if (q_exp_q.size() > 0) begin
            e = q_exp_q.pop_front();
            chk("q", int'(bus.q), e);
            chk("qb", int'(bus.qb), (~e) & 15);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      bus.en   = 1'b1;
      bus.up   = 1'b0;
      bus.load = 1'b0;
      bus.d    = 4'd0;
      #1;
      chk("reset_q", int'(bus.q), 0);
      chk("reset_qb", int'(bus.qb), 15);
      chk("reset_tc_down", int'(bus.tc), 1);
      @(negedge clk);
      rst    = 1'b0;
      bus.en = 1'b0;
      m      = 0;
      @(negedge clk);

      // Count to 7, then hit reset between edges.
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 0);
      bus.en = 1'b1;
      bus.up = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_q", int'(bus.q), 0);
      chk("async_rst_qb", int'(bus.qb), 15);
      bus.up = 1'b0;
      #1;
      chk("rst_tc_down", int'(bus.tc), 1);
      @(posedge clk);
      #1;
      chk("rst_hold_q", int'(bus.q), 0);
      @(negedge clk);
      rst = 1'b0;
      m   = 0;

      // Up count 12 edges from 0 (wraps through 9 -> 0).
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 0);

      // Down count from 0.
      step(1'b0, 1'b0, 1'b1, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0);

      // Load beats count; then clamp an out-of-range value.
      step(1'b1, 1'b1, 1'b1, 5);
      step(1'b1, 1'b1, 1'b1, 13);
      step(1'b0, 1'b1, 1'b1, 15);

      // Hold, then flip direction every cycle from 3.
      for (int i = 0; i < 4; i++) step(1'b0, i[0], 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 3);
      for (int i = 0; i < 4; i++) step(1'b1, ~i[0], 1'b0, 0);

      // Range ends (saturate or wrap depending on build).
      step(1'b0, 1'b0, 1'b1, 8);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 1);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
      end

      step(1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      n_cmp++;
      if (q_exp_q.size() != 0 || tc_exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q_exp_q.size() + tc_exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
